// File: rtl/mul_partial_resolver_pkg.sv
// Shared constants and types for the carry-save partial-product resolver.
package mul_partial_resolver_pkg;

  localparam int unsigned WordBits        = 8;
  localparam int unsigned MulPartialBits  = 23;
  localparam int unsigned MulResultBits   = 24;
  localparam int unsigned ResolverWords   = (MulResultBits + WordBits - 1) / WordBits;
  localparam int unsigned ResolverIdxBits = (ResolverWords > 1) ? $clog2(ResolverWords) : 1;

  typedef enum logic {ResIdle, ResRun} resolver_state_e;

  typedef logic [WordBits-1:0] word_t;

endpackage

// File: rtl/mul_partial_resolver_if.sv
// Input product handshake plus word-serial output stream of the resolver.
interface mul_partial_resolver_if #(
  parameter int unsigned PartialBits = mul_partial_resolver_pkg::MulPartialBits + 1,
  parameter int unsigned WordBits    = mul_partial_resolver_pkg::WordBits,
  parameter int unsigned IdxBits     = mul_partial_resolver_pkg::ResolverIdxBits
);

  logic                   in_valid;
  logic                   in_ready;
  logic [PartialBits-1:0] part_nr;
  logic [PartialBits-1:0] part_r;
  logic                   out_valid;
  logic                   out_ready;
  logic [WordBits-1:0]    out_word;
  logic [IdxBits-1:0]     out_idx;
  logic                   out_last;
  logic                   ovf;

  // Producer of products and consumer of resolved words.
  modport master (
    output in_valid, part_nr, part_r, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, ovf
  );

  // The resolver itself.
  modport slave (
    input  in_valid, part_nr, part_r, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, ovf
  );

endinterface

// File: rtl/mul_partial_resolver_word_cpa.sv
// One word-wide carry-propagate adder slice.
module mul_partial_resolver_word_cpa #(
  parameter int unsigned WordBits = mul_partial_resolver_pkg::WordBits
) (
  input  logic [WordBits-1:0] a,
  input  logic [WordBits-1:0] b,
  input  logic                cin,
  output logic [WordBits-1:0] sum_c,
  output logic                cout_c
);

  localparam int unsigned SumBits = WordBits + 1;

  logic [SumBits-1:0] total;

  assign total           = SumBits'(a) + SumBits'(b) + SumBits'(cin);
  assign {cout_c, sum_c} = total;

endmodule

// File: rtl/mul_partial_resolver.sv
// Resolves two carry-save partials into a non-redundant product, one word per
// handshake, LSW first, using a single time-multiplexed adder slice.
module mul_partial_resolver #(
  parameter int unsigned WordBits    = mul_partial_resolver_pkg::WordBits,
  parameter int unsigned PartialBits = mul_partial_resolver_pkg::MulPartialBits + 1,
  parameter int unsigned ResultBits  = mul_partial_resolver_pkg::MulResultBits
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_partial_resolver_if.slave bus
);

  import mul_partial_resolver_pkg::*;

  localparam int unsigned NumWords  = (ResultBits + WordBits - 1) / WordBits;
  localparam int unsigned IdxBits   = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned StoreBits = NumWords * WordBits;
  localparam int unsigned TopBits   = ResultBits - (NumWords - 1) * WordBits;

  localparam logic [IdxBits-1:0]  LastIdx = IdxBits'(NumWords - 1);
  // Bits of the top word that still belong to the kept product.
  localparam logic [WordBits-1:0] TopMask = {WordBits{1'b1}} >> (WordBits - TopBits);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IdxBits-1:0]  idx_q, idx_d;
  logic [WordBits-1:0] word_q, word_d;
  logic                cout_q, cout_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;
  logic                hi_nz_q, hi_nz_d;

  logic [WordBits-1:0] a_mem [NumWords];
  logic [WordBits-1:0] b_mem [NumWords];

  logic [StoreBits-1:0] ext_nr;
  logic [StoreBits-1:0] ext_r;
  logic                 hi_nz_c;
  logic                 accept_c;

  logic [IdxBits-1:0]  nxt_idx_c;
  logic [WordBits-1:0] cpa_a;
  logic [WordBits-1:0] cpa_b;
  logic                cpa_cin;
  logic [WordBits-1:0] sum_c;
  logic                cout_c;
  logic                is_last_c;
  logic [WordBits-1:0] word_c;
  logic                carry_c;

  // Fit each partial to the operand store: zero-extend or truncate.
  if (PartialBits >= StoreBits) begin : g_trunc
    assign ext_nr = bus.part_nr[StoreBits-1:0];
    assign ext_r  = bus.part_r[StoreBits-1:0];
  end else begin : g_zext
    assign ext_nr = {{(StoreBits - PartialBits){1'b0}}, bus.part_nr};
    assign ext_r  = {{(StoreBits - PartialBits){1'b0}}, bus.part_r};
  end

  // Operand bits beyond the kept product width always signal overflow.
  if (PartialBits > ResultBits) begin : g_hi
    assign hi_nz_c = (|bus.part_nr[PartialBits-1:ResultBits]) |
                     (|bus.part_r[PartialBits-1:ResultBits]);
  end else begin : g_no_hi
    assign hi_nz_c = 1'b0;
  end

  assign accept_c  = (state_q == StIdle) && bus.in_valid && ready_q;
  assign nxt_idx_c = (idx_q == LastIdx) ? '0 : idx_q + IdxBits'(1);

  // Adder operands: word 0 straight from the bus on acceptance, else the next stored word.
  always_comb begin
    cpa_a     = a_mem[nxt_idx_c];
    cpa_b     = b_mem[nxt_idx_c];
    cpa_cin   = cout_q;
    is_last_c = (nxt_idx_c == LastIdx);
    if (state_q == StIdle) begin
      cpa_a     = ext_nr[WordBits-1:0];
      cpa_b     = ext_r[WordBits-1:0];
      cpa_cin   = 1'b0;
      is_last_c = (LastIdx == '0);
    end
  end

  mul_partial_resolver_word_cpa #(
    .WordBits (WordBits)
  ) u_cpa (
    .a      (cpa_a),
    .b      (cpa_b),
    .cin    (cpa_cin),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  // The top word is trimmed to the product width; anything above it counts as carry-out.
  assign word_c  = is_last_c ? (sum_c & TopMask) : sum_c;
  assign carry_c = is_last_c ? (cout_c | (|(sum_c & ~TopMask))) : cout_c;

  // Operand store, loaded once per accepted product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (accept_c) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        a_mem[i] <= ext_nr[i*WordBits +: WordBits];
        b_mem[i] <= ext_r[i*WordBits +: WordBits];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
      hi_nz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      hi_nz_q <= hi_nz_d;
    end
  end

  // Next state: accept in IDLE, advance one word per output handshake in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    last_d  = last_q;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    hi_nz_d = hi_nz_q;
    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (accept_c) begin
          state_d = StRun;
          idx_d   = '0;
          word_d  = word_c;
          cout_d  = carry_c;
          valid_d = 1'b1;
          last_d  = is_last_c;
          ready_d = 1'b0;
          ovf_d   = 1'b0;
          hi_nz_d = hi_nz_c;
        end
      end
      StRun: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_d = StIdle;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            ovf_d   = cout_q | hi_nz_q;
          end else begin
            idx_d  = nxt_idx_c;
            word_d = word_c;
            cout_d = carry_c;
            last_d = is_last_c;
          end
        end
      end
    endcase
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mul_partial_resolver.sv
// Self-checking bench: per-cycle arithmetic reference model plus directed and random products.
module tb_mul_partial_resolver;

  import mul_partial_resolver_pkg::*;

  localparam int unsigned WB = 8;
  localparam int unsigned PB = 24;
  localparam int unsigned RB = 24;
  localparam int unsigned IB = 2;
  localparam int          NW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  word_t got[$];
  int    got_cyc[$];

  mul_partial_resolver_if #(.PartialBits(PB), .WordBits(WB), .IdxBits(IB)) bus ();

  mul_partial_resolver #(
    .WordBits    (WB),
    .PartialBits (PB),
    .ResultBits  (RB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: full sum by plain arithmetic, split into words, one word per handshake.
  bit          m_valid = 1'b0;
  int          m_idx = 0;
  bit          m_ovf = 1'b0;
  bit          m_ovf_pend = 1'b0;
  logic [7:0]  m_words [3];
  logic [24:0] m_sum;

  assign m_sum = {1'b0, bus.part_nr} + {1'b0, bus.part_r};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ovf   <= 1'b0;
    end else if (!m_valid) begin
      if (bus.in_valid) begin
        for (int i = 0; i < NW; i++) m_words[i] <= m_sum[8*i +: 8];
        m_ovf_pend <= m_sum[24];
        m_ovf      <= 1'b0;
        m_valid    <= 1'b1;
        m_idx      <= 0;
      end
    end else if (bus.out_ready) begin
      if (m_idx == NW - 1) begin
        m_valid <= 1'b0;
        m_ovf   <= m_ovf_pend;
        m_idx   <= 0;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("in_ready", 32'(bus.in_ready), 32'(!m_valid));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (rst) begin
      chk("rst_word", 32'(bus.out_word), 32'd0);
      chk("rst_idx", 32'(bus.out_idx), 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
    end else if (m_valid) begin
      chk("out_word", 32'(bus.out_word), 32'(m_words[m_idx]));
      chk("out_idx", 32'(bus.out_idx), 32'(m_idx));
      chk("out_last", 32'(bus.out_last), 32'(m_idx == NW - 1));
    end else begin
      chk("idle_last", 32'(bus.out_last), 32'd0);
    end
  end

  // Record every word the consumer takes, with the cycle it was taken.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_word);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [23:0] nr, input logic [23:0] r);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.part_nr  = nr;
    bus.part_r   = r;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n >= 100), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.part_nr  = 24'($urandom);
    bus.part_r   = 24'($urandom);
  endtask

  task automatic wait_words(input int k);
    int n = 0;
    while (got.size() < k && n < 200) begin
      tick();
      n++;
    end
    chk("words_timeout", 32'(n >= 200), 32'd0);
  endtask

  task automatic check_words(input string name, input int base, input logic [23:0] exp);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_w%0d", name, i), 32'(got[base + i]), 32'(exp[8*i +: 8]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [23:0] nr;
    logic [23:0] r;
    logic [23:0] p;
    logic [23:0] res;
    logic [24:0] s;
    int unsigned a;
    int unsigned b;

    bus.in_valid  = 1'b0;
    bus.part_nr   = '0;
    bus.part_r    = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_word", 32'(bus.out_word), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    #2 rst = 1'b0;
    tick();

    // Simple carry across word 0, consumer always ready.
    got.delete(); got_cyc.delete();
    send(24'h0000FF, 24'h000001);
    wait_words(3);
    chk("t1_count", 32'(got.size()), 32'd3);
    check_words("t1", 0, 24'h000100);
    chk("t1_span", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
    chk("t1_ovf", 32'(bus.ovf), 32'd0);

    // Full-width carry ripple with carry-out.
    got.delete(); got_cyc.delete();
    send(24'hFFFFFF, 24'hFFFFFF);
    wait_words(3);
    check_words("t2", 0, 24'hFFFFFE);
    chk("t2_ovf", 32'(bus.ovf), 32'd1);

    // Three-cycle stall on word 1.
    got.delete(); got_cyc.delete();
    send(24'h123456, 24'h000000);
    tick();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    wait_words(3);
    chk("t3_count", 32'(got.size()), 32'd3);
    check_words("t3", 0, 24'h123456);
    chk("t3_stall_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd4);
    chk("t3_ovf", 32'(bus.ovf), 32'd0);

    // in_valid held through RUN with new data: second product waits for the idle cycle.
    got.delete(); got_cyc.delete();
    bus.in_valid = 1'b1;
    bus.part_nr  = 24'h0A0B0C;
    bus.part_r   = 24'h010101;
    tick();
    bus.part_nr  = 24'h00FF00;
    bus.part_r   = 24'h000100;
    wait_words(6);
    bus.in_valid = 1'b0;
    chk("t4_count", 32'(got.size()), 32'd6);
    check_words("t4a", 0, 24'h0B0C0D);
    check_words("t4b", 3, 24'h010000);
    chk("t4_gap", 32'(got_cyc[3] - got_cyc[2]), 32'd2);
    repeat (2) tick();

    // Asynchronous reset after word 0, then a clean product.
    got.delete(); got_cyc.delete();
    send(24'h00AA55, 24'h001111);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_rst_last", 32'(bus.out_last), 32'd0);
    #3 rst = 1'b0;
    chk("t5_words_before_rst", 32'(got.size()), 32'd1);
    tick();
    got.delete(); got_cyc.delete();
    send(24'h345678, 24'h111111);
    wait_words(3);
    check_words("t5", 0, 24'h456789);

    // Random operands and multiplier-style carry-save pairs, random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        a  = (k == 0) ? 32'd4095 : $urandom_range(0, 4095);
        b  = (k == 0) ? 32'd4095 : $urandom_range(0, 4095);
        p  = 24'(a * b);
        r  = 24'($urandom);
        nr = p - r;
      end else begin
        a  = 0;
        b  = 0;
        nr = 24'($urandom);
        r  = 24'($urandom);
        p  = nr + r;
      end
      s = {1'b0, nr} + {1'b0, r};
      got.delete(); got_cyc.delete();
      send(nr, r);
      wait_words(3);
      res = {got[2], got[1], got[0]};
      chk($sformatf("rnd%0d_count", k), 32'(got.size()), 32'd3);
      chk($sformatf("rnd%0d_product", k), 32'(res), 32'(p));
      chk($sformatf("rnd%0d_ovf", k), 32'(bus.ovf), 32'(s[24]));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
